// File: rtl/bt656_if.sv
// BT.656 byte stream in, decoded pixel/timing/status out.
// master = decoder side, slave = stream source / pixel consumer.
interface bt656_if;
  logic [7:0]  bt656_data;
  logic        vs;
  logic        f;
  logic        pixel_de;
  logic [15:0] pixel_yc;
  logic [11:0] active_width;
  logic [11:0] active_height;
  logic        locked;
  logic        protect_err;

  modport master (
    input  bt656_data,
    output vs, f, pixel_de, pixel_yc, active_width, active_height, locked, protect_err
  );

  modport slave (
    output bt656_data,
    input  vs, f, pixel_de, pixel_yc, active_width, active_height, locked, protect_err
  );
endinterface

// File: rtl/bt656_decoder.sv
// BT.656 timing-code tracker and pixel unpacker with width/height measurement
// and field-height based sync lock.
module bt656_decoder #(
  parameter int LOCK_FIELDS    = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic     pixel_clk,
  input  logic     rst_n,
  bt656_if.master  vid
);
  localparam int LC_W = $clog2(LOCK_FIELDS + 1);
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {HUNT, P1, P2, P3, ACTIVE} state_e;

  state_e      state_q, state_d;
  logic [1:0]  phase_q, phase_d;
  logic [7:0]  chroma_q, chroma_d;
  logic [15:0] yc_q, yc_d;
  logic        de_q, de_d;
  logic        perr_q, perr_d;
  logic        vs_q, vs_d;
  logic        f_q, f_d;
  logic [11:0] wcnt_q, wcnt_d;
  logic [11:0] width_q, width_d;
  logic [11:0] hcnt_q, hcnt_d;
  logic [11:0] height_q, height_d;
  logic [LC_W-1:0] lcnt_q, lcnt_d;
  logic        locked_q, locked_d;
  logic [TO_W-1:0] to_q, to_d;

  logic [7:0] din;
  logic       xf, xv, xh, xy_ok, code_ok, timeout;

  assign din   = vid.bt656_data;
  assign xf    = din[6];
  assign xv    = din[5];
  assign xh    = din[4];
  assign xy_ok = din[7] && (din[3] == (xv ^ xh)) && (din[2] == (xf ^ xh)) &&
                 (din[1] == (xf ^ xv)) && (din[0] == (xf ^ xv ^ xh));
  assign code_ok = (state_q == P3) && xy_ok;
  // A valid code in the same cycle as expiry suppresses the timeout.
  assign timeout = !code_ok && (to_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    chroma_d = chroma_q;
    yc_d     = yc_q;
    de_d     = 1'b0;
    perr_d   = 1'b0;
    vs_d     = vs_q;
    f_d      = f_q;
    wcnt_d   = wcnt_q;
    width_d  = width_q;
    hcnt_d   = hcnt_q;
    height_d = height_q;
    lcnt_d   = lcnt_q;
    locked_d = locked_q;
    to_d     = to_q + TO_W'(1);

    unique case (state_q)
      HUNT: if (din == 8'hFF) state_d = P1;
      P1:   state_d = (din == 8'h00) ? P2 : HUNT;
      P2:   state_d = (din == 8'h00) ? P3 : (din == 8'hFF) ? P1 : HUNT;
      P3: begin
        state_d = HUNT;
        if (xy_ok) begin
          f_d  = xf;
          vs_d = xv;
          to_d = '0;
          if (!xh) wcnt_d = '0;
          if (xh && wcnt_q != 12'd0) width_d = wcnt_q;
          if (!xh && !xv) begin
            state_d = ACTIVE;
            phase_d = 2'd0;
            if (hcnt_q != 12'hFFF) hcnt_d = hcnt_q + 12'd1;
          end
          // Field boundary: latch height and grade lock on its stability.
          if (xv && !vs_q) begin
            height_d = hcnt_q;
            hcnt_d   = '0;
            if (hcnt_q == height_q) begin
              if (lcnt_q >= LC_W'(LOCK_FIELDS - 1)) begin
                lcnt_d   = LC_W'(LOCK_FIELDS);
                locked_d = 1'b1;
              end else begin
                lcnt_d = lcnt_q + LC_W'(1);
              end
            end else begin
              lcnt_d   = '0;
              locked_d = 1'b0;
            end
          end
        end else begin
          perr_d   = 1'b1;
          locked_d = 1'b0;
        end
      end
      ACTIVE: begin
        if (din == 8'hFF) begin
          state_d = P1;
        end else begin
          phase_d = phase_q + 2'd1;
          if (!phase_q[0]) begin
            chroma_d = din;
          end else begin
            yc_d = {din, chroma_q};
            de_d = 1'b1;
            if (wcnt_q != 12'hFFF) wcnt_d = wcnt_q + 12'd1;
          end
        end
      end
      default: state_d = HUNT;
    endcase

    if (timeout) begin
      locked_d = 1'b0;
      lcnt_d   = '0;
      state_d  = HUNT;
      de_d     = 1'b0;
      to_d     = '0;
    end
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= HUNT;
      phase_q  <= '0;
      chroma_q <= '0;
      yc_q     <= '0;
      de_q     <= 1'b0;
      perr_q   <= 1'b0;
      vs_q     <= 1'b0;
      f_q      <= 1'b0;
      wcnt_q   <= '0;
      width_q  <= '0;
      hcnt_q   <= '0;
      height_q <= '0;
      lcnt_q   <= '0;
      locked_q <= 1'b0;
      to_q     <= '0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      chroma_q <= chroma_d;
      yc_q     <= yc_d;
      de_q     <= de_d;
      perr_q   <= perr_d;
      vs_q     <= vs_d;
      f_q      <= f_d;
      wcnt_q   <= wcnt_d;
      width_q  <= width_d;
      hcnt_q   <= hcnt_d;
      height_q <= height_d;
      lcnt_q   <= lcnt_d;
      locked_q <= locked_d;
      to_q     <= to_d;
    end
  end

  assign vid.vs            = vs_q;
  assign vid.f             = f_q;
  assign vid.pixel_de      = de_q;
  assign vid.pixel_yc      = yc_q;
  assign vid.active_width  = width_q;
  assign vid.active_height = height_q;
  assign vid.locked        = locked_q;
  assign vid.protect_err   = perr_q;
endmodule

// File: tb/tb_bt656_decoder.sv
// Line/field-level stream generator with a scoreboard for pixels and error pulses,
// plus a field-level model of width, height, lock and timing flags.
module tb_bt656_decoder;
  logic pixel_clk = 1'b0;
  logic rst_n     = 1'b0;
  bt656_if vif();

  bt656_decoder #(.LOCK_FIELDS(2), .TIMEOUT_CYCLES(4096)) dut (
    .pixel_clk (pixel_clk),
    .rst_n     (rst_n),
    .vid       (vif)
  );

  always #5 pixel_clk = ~pixel_clk;

  int n_checks = 0;
  int n_err    = 0;
  logic [15:0] exp_q[$];
  int perr_exp = 0;

  // model of the stream as seen by a BT.656 receiver
  bit mvs, mf, mactive, mlocked;
  int cur_w, exp_w, mhcnt, mheight, mlcnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mvs = 0; mf = 0; mactive = 0; mlocked = 0;
    cur_w = 0; exp_w = 0; mhcnt = 0; mheight = 0; mlcnt = 0;
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge pixel_clk);
    vif.bt656_data = b;
  endtask

  function automatic logic [7:0] xy(input bit f, input bit v, input bit h);
    return {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h};
  endfunction

  task automatic field_done();
    if (mhcnt == mheight) begin
      if (mlcnt < 2) mlcnt++;
      if (mlcnt == 2) mlocked = 1;
    end else begin
      mlcnt = 0;
      mlocked = 0;
    end
    mheight = mhcnt;
    mhcnt = 0;
  endtask

  task automatic code(input bit f, input bit v, input bit h, input bit bad);
    logic [7:0] c;
    c = xy(f, v, h);
    if (bad) c = c ^ 8'h01;
    send(8'hFF); send(8'h00); send(8'h00); send(c);
    if (bad) begin
      perr_exp++;
      mlocked = 0;
      mactive = 0;
    end else begin
      if (h) begin
        if (cur_w != 0) exp_w = cur_w;
      end else cur_w = 0;
      mactive = !h && !v;
      if (!h && !v) mhcnt++;
      if (v && !mvs) field_done();
      mvs = v;
      mf  = f;
    end
  endtask

  task automatic px(input logic [7:0] c, input logic [7:0] y);
    send(c);
    send(y);
    if (mactive) begin
      exp_q.push_back({y, c});
      if (cur_w < 4095) cur_w++;
    end
  endtask

  task automatic rpx(input int n);
    for (int i = 0; i < n; i++)
      px(8'($urandom_range(1, 254)), 8'($urandom_range(1, 254)));
  endtask

  task automatic check_state();
    chk("vs", 32'(vif.vs), 32'(mvs));
    chk("f", 32'(vif.f), 32'(mf));
    chk("active_width", 32'(vif.active_width), 32'(exp_w));
    chk("active_height", 32'(vif.active_height), 32'(mheight));
    chk("locked", 32'(vif.locked), 32'(mlocked));
  endtask

  task automatic line(input bit f, input bit v, input int n, input bit bad);
    code(f, v, 1'b1, 1'b0);
    send(8'h80);
    check_state();
    send(8'h10); send(8'h80); send(8'h10);
    code(f, v, 1'b0, bad);
    rpx(n);
  endtask

  task automatic field(input bit f, input int nact, input int w, input int bad_at);
    repeat (2) line(f, 1'b1, 4, 1'b0);
    for (int i = 0; i < nact; i++)
      line(f, 1'b0, (w != 0) ? w : $urandom_range(4, 24), i == bad_at);
  endtask

  // scoreboard monitor
  always @(negedge pixel_clk) begin
    if (rst_n) begin
      if (vif.pixel_de) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL pixel_de: unexpected pixel %0h, nothing expected at %0t", vif.pixel_yc, $time);
        end else chk("pixel_yc", 32'(vif.pixel_yc), 32'(exp_q.pop_front()));
      end
      if (vif.protect_err) begin
        n_checks++;
        if (perr_exp == 0) begin
          n_err++;
          $display("FAIL protect_err: got pulse expected none at %0t", $time);
        end else perr_exp--;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach end, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err + 1);
    $fatal(1);
  end

  initial begin
    vif.bt656_data = 8'h00;
    model_reset();
    repeat (3) @(negedge pixel_clk);
    chk("rst pixel_de", 32'(vif.pixel_de), 0);
    chk("rst pixel_yc", 32'(vif.pixel_yc), 0);
    chk("rst locked", 32'(vif.locked), 0);
    chk("rst status", {vif.vs, vif.f, vif.protect_err, vif.active_width, vif.active_height}, 0);
    rst_n = 1'b1;
    repeat (4) send(8'h10);

    // directed SAV + two pixels
    code(1'b0, 1'b0, 1'b0, 1'b0);
    px(8'h80, 8'h10);
    px(8'h90, 8'h20);
    line(1'b0, 1'b0, 6, 1'b0);

    field(1'b1, 3, 720, -1);
    field(1'b0, 6, 0, -1); field(1'b1, 6, 0, -1); field(1'b0, 6, 0, -1); field(1'b1, 6, 0, -1);
    field(1'b0, 5, 0, -1); field(1'b1, 5, 0, -1); field(1'b0, 5, 0, -1); field(1'b1, 5, 0, -1);
    field(1'b0, 5, 0, 2);
    field(1'b1, 5, 0, -1); field(1'b0, 5, 0, -1); field(1'b1, 5, 0, -1); field(1'b0, 5, 0, -1);

    // timeout: last valid code, then idle bytes
    code(1'b1, 1'b1, 1'b1, 1'b0);
    send(8'h80);
    check_state();
    for (int j = 2; j <= 4095; j++) send(8'h10);
    chk("locked before timeout", 32'(vif.locked), 32'(mlocked));
    repeat (3) send(8'h10);
    chk("locked after timeout", 32'(vif.locked), 0);
    mlocked = 0;
    mlcnt = 0;

    field(1'b0, 5, 0, -1);
    // reset in the middle of an active line
    code(1'b0, 1'b0, 1'b1, 1'b0);
    code(1'b0, 1'b0, 1'b0, 1'b0);
    rpx(5);
    @(negedge pixel_clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst pixel_de", 32'(vif.pixel_de), 0);
    chk("midrst pixel_yc", 32'(vif.pixel_yc), 0);
    chk("midrst status", {vif.vs, vif.f, vif.protect_err, vif.locked, vif.active_width, vif.active_height}, 0);
    model_reset();
    repeat (3) send(8'($urandom_range(1, 254)));
    rst_n = 1'b1;
    repeat (16) send(8'($urandom_range(1, 254)));

    field(1'b1, 5, 0, -1); field(1'b0, 5, 0, -1); field(1'b1, 5, 0, -1); field(1'b0, 5, 0, -1);
    code(1'b1, 1'b1, 1'b1, 1'b0);
    send(8'h80);
    check_state();
    repeat (6) send(8'h10);
    chk("pixels outstanding", 32'(exp_q.size()), 0);
    chk("protect pulses outstanding", 32'(perr_exp), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
